// File: rtl/color_encoder_if.sv
// color_encoder_if
//   Groups the two valid/ready handshakes of the colour encoder.
//   Colour input side : in_valid, in_color (to encoder), in_ready (from encoder)
//   Vector output side: vec_valid, colorVec, match_err, slot_count (from encoder),
//                       vec_ready (to encoder)
//   master: the producer/consumer environment; slave: the encoder itself.
interface color_encoder_if;
  logic        in_valid;
  logic [11:0] in_color;
  logic        in_ready;
  logic        vec_valid;
  logic        vec_ready;
  logic [7:0]  colorVec;
  logic        match_err;
  logic [2:0]  slot_count;

  modport master (
    output in_valid, in_color, vec_ready,
    input  in_ready, vec_valid, colorVec, match_err, slot_count
  );

  modport slave (
    input  in_valid, in_color, vec_ready,
    output in_ready, vec_valid, colorVec, match_err, slot_count
  );
endinterface

// File: rtl/color_encoder.sv
// color_encoder
//   Maps incoming 12-bit RGB colours to 2-bit palette indices and packs four
//   indices into an 8-bit vector (slot0 in bits [1:0]) for the sequence logic.
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   color_shift palette select per accepted colour (0 = A, 1 = B)
//   clear       synchronous abort of a partial or held vector (highest priority)
//   bus         handshake bundle (slave side): in_valid/in_color/in_ready in,
//               vec_valid/vec_ready/colorVec/match_err/slot_count out
module color_encoder #(
  parameter logic [11:0] COLOR1_A = 12'hF00,
  parameter logic [11:0] COLOR2_A = 12'h0F0,
  parameter logic [11:0] COLOR3_A = 12'h00F,
  parameter logic [11:0] COLOR4_A = 12'hFF0,
  parameter logic [11:0] COLOR1_B = 12'h0FF,
  parameter logic [11:0] COLOR2_B = 12'hF0F,
  parameter logic [11:0] COLOR3_B = 12'hFF0,
  parameter logic [11:0] COLOR4_B = 12'h80C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            color_shift,
  input  logic            clear,
  color_encoder_if.slave  bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t      state;
  logic [2:0]  slot_count;
  logic [5:0]  assembly;   // slots 0..2; slot 3 goes straight into colorVec
  logic        err_acc;
  logic [7:0]  color_vec;
  logic        match_err;

  logic [1:0]  idx;
  logic        hit;
  logic        accept;

  // Palette lookup; if-else chain gives lowest-index priority on duplicates.
  always_comb begin
    idx = 2'd0;
    hit = 1'b0;
    if (!color_shift) begin
      if      (bus.in_color == COLOR1_A) begin idx = 2'd0; hit = 1'b1; end
      else if (bus.in_color == COLOR2_A) begin idx = 2'd1; hit = 1'b1; end
      else if (bus.in_color == COLOR3_A) begin idx = 2'd2; hit = 1'b1; end
      else if (bus.in_color == COLOR4_A) begin idx = 2'd3; hit = 1'b1; end
    end else begin
      if      (bus.in_color == COLOR1_B) begin idx = 2'd0; hit = 1'b1; end
      else if (bus.in_color == COLOR2_B) begin idx = 2'd1; hit = 1'b1; end
      else if (bus.in_color == COLOR3_B) begin idx = 2'd2; hit = 1'b1; end
      else if (bus.in_color == COLOR4_B) begin idx = 2'd3; hit = 1'b1; end
    end
  end

  assign accept = bus.in_valid && (state == COLLECT) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      slot_count <= '0;
      assembly   <= '0;
      err_acc    <= 1'b0;
      color_vec  <= '0;
      match_err  <= 1'b0;
    end else if (clear) begin
      // colorVec/match_err deliberately keep the last completed vector.
      state      <= COLLECT;
      slot_count <= '0;
      assembly   <= '0;
      err_acc    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (slot_count == 3'd3) begin
              color_vec  <= {idx, assembly};
              match_err  <= err_acc | ~hit;
              slot_count <= 3'd4;
              state      <= HOLD;
            end else begin
              assembly[{slot_count[1:0], 1'b0} +: 2] <= idx;
              err_acc    <= err_acc | ~hit;
              slot_count <= slot_count + 3'd1;
            end
          end
        end
        HOLD: begin
          if (bus.vec_ready) begin
            state      <= COLLECT;
            slot_count <= '0;
            assembly   <= '0;
            err_acc    <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready   = (state == COLLECT);
  assign bus.vec_valid  = (state == HOLD);
  assign bus.colorVec   = color_vec;
  assign bus.match_err  = match_err;
  assign bus.slot_count = slot_count;

endmodule
